// File: rtl/uart_pkg.sv
// Shared encodings for the buffered UART transmitter: line configuration fields and FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone  = 2'b00,
    ParEven  = 2'b01,
    ParOdd   = 2'b10,
    ParNone2 = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    Bits5 = 2'b00,
    Bits6 = 2'b01,
    Bits7 = 2'b10,
    Bits8 = 2'b11
  } data_bits_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // 5..8 data bits map onto last bit index 4..7.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] enc);
    return {1'b1, enc};
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == ParEven) || (mode == ParOdd);
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] enc,
                                      input logic [1:0] mode);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - enc);
    return (^(data & mask)) ^ (mode == ParOdd);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous word FIFO with registered occupancy count; pushes while full are ignored.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
    if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of bytes feeding a framing FSM whose configuration is captured
// per frame when the word is popped.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DIVW  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIVW-1:0]        divisor,
  input  logic [1:0]             data_bits,
  input  logic [1:0]             parity_mode,
  input  logic                   stop2,
  input  logic [7:0]             in,
  input  logic                   we,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   full,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  import uart_pkg::*;

  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       pop, load;

  uart_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (we),
    .wdata_i (in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  tx_state_e       state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      last_q, last_d;
  logic [2:0]      bit_q, bit_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic            stop2_q, stop2_d;
  logic            stop_q, stop_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic            bit_end;

  assign bit_end  = (cnt_q == div_q - DIVW'(1));
  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign ready    = fifo_empty && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    shift_d   = shift_q;
    last_d    = last_q;
    bit_d     = bit_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    stop_d    = stop_q;
    pop       = 1'b0;
    load      = 1'b0;
    cnt_d     = bit_end ? '0 : cnt_q + DIVW'(1);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        load  = !fifo_empty;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          stop_d  = 1'b0;
          if (bit_q == last_q) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) stop_d = 1'b1;
          else if (!fifo_empty)  load   = 1'b1;
          else                   state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Configuration is sampled with the word so mid-frame input changes cannot corrupt a frame.
    if (load) begin
      pop       = 1'b1;
      state_d   = StStart;
      cnt_d     = '0;
      div_d     = (divisor < DIVW'(2)) ? DIVW'(2) : divisor;
      shift_d   = fifo_rdata;
      last_d    = last_bit_idx(data_bits);
      par_en_d  = parity_enabled(parity_mode);
      par_bit_d = parity_bit(fifo_rdata, data_bits, parity_mode);
      stop2_d   = stop2;
    end

    unique case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase

    // A drop in the same cycle as a clear wins so no lost write goes unreported.
    ovf_d = (we && full) || (ovf_q && !ovf_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= DIVW'(2);
      cnt_q     <= '0;
      shift_q   <= '0;
      last_q    <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table-driven single frames, hand-built corner sequences and random bursts
// compared cycle by cycle against a serial-line model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIVW  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] divisor;
  logic [1:0]  data_bits, parity_mode;
  logic        stop2;
  logic [7:0]  in;
  logic        we, ovf_clr;
  logic        tx, full, ready, overflow;
  logic [2:0]  count;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .DIVW (DIVW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .divisor     (divisor),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .in          (in),
    .we          (we),
    .ovf_clr     (ovf_clr),
    .tx          (tx),
    .full        (full),
    .ready       (ready),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  dbits;
    logic [1:0]  par;
    logic        stop2;
  } frame_t;

  typedef struct {
    frame_t      f;
    logic [11:0] pat;
    int          len;
    int          clocks;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wq[$];
  bit         expq[$];
  int         chg_at = -1;
  int         clr_at = -1;
  frame_t     alt;
  logic       full_h[16];
  logic       ovf_h[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_cfg(input frame_t f);
    divisor     = f.div;
    data_bits   = f.dbits;
    parity_mode = f.par;
    stop2       = f.stop2;
  endtask

  // Serial-line model: one frame appended to the per-clock expected tx stream.
  function automatic void add_frame(input frame_t f);
    bit b[$];
    int n, hold, ones;
    n    = int'(f.dbits) + 5;
    hold = (f.div < 2) ? 2 : int'(f.div);
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(f.data[i]);
      ones += int'(f.data[i]);
    end
    if (f.par == 2'b01) b.push_back((ones % 2) == 1);
    if (f.par == 2'b10) b.push_back((ones % 2) == 0);
    b.push_back(1'b1);
    if (f.stop2) b.push_back(1'b1);
    foreach (b[i]) repeat (hold) expq.push_back(b[i]);
  endfunction

  // Writes wq on consecutive cycles from idle, then compares tx and ready every cycle.
  task automatic run_stream(input string name);
    int   total, bad;
    logic e_tx, e_rdy;
    logic [1:0] got, want;
    total = expq.size() + 4;
    bad   = -1;
    got   = '0;
    want  = '0;
    for (int j = 0; j < total; j++) begin
      we = (j < wq.size());
      in = (j < wq.size()) ? wq[j] : 8'h00;
      ovf_clr = (j == clr_at);
      if (j == chg_at) apply_cfg(alt);
      tick();
      if (j < 16) begin
        full_h[j] = full;
        ovf_h[j]  = overflow;
      end
      e_tx  = (j >= 2 && (j - 2) < expq.size()) ? expq[j-2] : 1'b1;
      e_rdy = (j >= expq.size() + 1);
      if (bad < 0 && (tx !== e_tx || ready !== e_rdy)) begin
        bad  = j;
        got  = {tx, ready};
        want = {e_tx, e_rdy};
      end
    end
    we      = 1'b0;
    ovf_clr = 1'b0;
    chg_at  = -1;
    clr_at  = -1;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: cycle %0d {tx,ready} got %b expected %b", name, bad, got, want);
    end
    check({name, "_count"}, 32'(count), 32'd0);
    wq.delete();
    expq.delete();
  endtask

  vec_t   vt[6];
  frame_t f;
  int     n, errs;

  initial begin
    vt[0] = '{'{8'h55, 16'd4, 2'b11, 2'b00, 1'b0}, 12'h2AA, 10, 40};
    vt[1] = '{'{8'h41, 16'd3, 2'b10, 2'b01, 1'b1}, 12'h682, 11, 33};
    vt[2] = '{'{8'h00, 16'd2, 2'b11, 2'b10, 1'b0}, 12'h600, 11, 22};
    vt[3] = '{'{8'hFF, 16'd0, 2'b00, 2'b00, 1'b0}, 12'h07E, 7, 14};
    vt[4] = '{'{8'hC5, 16'd1, 2'b01, 2'b10, 1'b1}, 12'h38A, 10, 20};
    vt[5] = '{'{8'hA3, 16'd5, 2'b10, 2'b11, 1'b0}, 12'h146, 9, 45};

    // Reset with a write strobe held: the write must be ignored.
    reset = 1'b1; we = 1'b1; in = 8'h99; ovf_clr = 1'b0;
    divisor = 16'd4; data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    tick();
    tick();
    reset = 1'b0; we = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();

    foreach (vt[i]) begin
      apply_cfg(vt[i].f);
      wq.push_back(vt[i].f.data);
      for (int b = 0; b < vt[i].len; b++)
        repeat (vt[i].clocks / vt[i].len) expq.push_back(vt[i].pat[b]);
      run_stream($sformatf("vec%0d", i));
    end
    check("vec_overflow", 32'(overflow), 32'd0);

    // Overfill a depth-4 FIFO: fifth write fills it, sixth is dropped.
    f = '{8'h10, 16'd16, 2'b11, 2'b00, 1'b0};
    apply_cfg(f);
    for (int w = 0; w < 6; w++) begin
      wq.push_back(8'h10 + 8'(w));
      if (w < 5) begin
        f.data = 8'h10 + 8'(w);
        add_frame(f);
      end
    end
    run_stream("burst");
    check("burst_full4", 32'(full_h[3]), 32'd0);
    check("burst_full5", 32'(full_h[4]), 32'd1);
    check("burst_ovf5", 32'(ovf_h[4]), 32'd0);
    check("burst_ovf6", 32'(ovf_h[5]), 32'd1);
    check("burst_ovf_end", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Drop and clear in the same cycle: overflow must still be set.
    f = '{8'h20, 16'd2, 2'b00, 2'b00, 1'b0};
    apply_cfg(f);
    for (int w = 0; w < 6; w++) begin
      wq.push_back(8'h20 + 8'(w));
      if (w < 5) begin
        f.data = 8'h20 + 8'(w);
        add_frame(f);
      end
    end
    clr_at = 5;
    run_stream("drop_clr");
    check("drop_clr_ovf", 32'(ovf_h[5]), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Divisor change mid-frame only affects the next frame.
    f = '{8'hA5, 16'd4, 2'b11, 2'b00, 1'b0};
    apply_cfg(f);
    wq.push_back(8'hA5);
    wq.push_back(8'h3C);
    add_frame(f);
    f.data = 8'h3C;
    f.div  = 16'd8;
    add_frame(f);
    alt = f;
    chg_at = 6;
    run_stream("div_change");

    // Reset in the middle of DATA with words still queued.
    f = '{8'h00, 16'd4, 2'b11, 2'b00, 1'b0};
    apply_cfg(f);
    for (int w = 0; w < 3; w++) begin
      we = 1'b1; in = 8'h00;
      tick();
    end
    we = 1'b0;
    repeat (12) tick();
    check("mid_tx_low", 32'(tx), 32'd0);
    check("mid_count", 32'(count), 32'd2);
    reset = 1'b1; we = 1'b1; in = 8'hFF;
    tick();
    reset = 1'b0; we = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_count", 32'(count), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (tx !== 1'b1 || count !== 3'd0) errs++;
    end
    check("abort_quiet", 32'(errs), 32'd0);

    // Random bursts against the model.
    for (int r = 0; r < 12; r++) begin
      f.div   = 16'($urandom_range(0, 6));
      f.dbits = 2'($urandom_range(0, 3));
      f.par   = 2'($urandom_range(0, 3));
      f.stop2 = 1'($urandom_range(0, 1));
      apply_cfg(f);
      n = int'($urandom_range(1, 6));
      for (int w = 0; w < n; w++) begin
        wq.push_back(8'($urandom));
        if (w < DEPTH + 1) begin
          f.data = wq[w];
          add_frame(f);
        end
      end
      if (n == 1 && $urandom_range(0, 1) == 1) begin
        alt.data  = 8'h00;
        alt.div   = 16'($urandom_range(0, 9));
        alt.dbits = 2'($urandom_range(0, 3));
        alt.par   = 2'($urandom_range(0, 3));
        alt.stop2 = 1'($urandom_range(0, 1));
        chg_at    = int'($urandom_range(2, 8));
      end
      run_stream($sformatf("rand%0d", r));
      check($sformatf("rand%0d_ovf", r), 32'(overflow), (n > DEPTH + 1) ? 32'd1 : 32'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
